spike_counter_bank: RTL and testbench
=====================================

# spike_counter_bank

Counts output-layer spikes per class over a programmable inference window and presents the frozen per-class counts to the argmax/prediction stage. Sits directly upstream of the max-spike classifier: its `count_o` lanes drive that stage's per-digit spike-count inputs, and `valid_o` qualifies them. One window per `start_i`; results are held stable until the next window completes.

## Interface
- `N_CLASSES`, default 10: number of output neurons / classes.
- `CNT_W`, default 8: per-class counter width; counters saturate at 2^CNT_W-1.
- `WIN_W`, default 8: width of the window-length input.

- `clk_i`, input, 1: the block's single clock.
- `rst_ni`, input, 1: asynchronous, active-low reset.
- `start_i`, input, 1: starts a new counting window.
- `window_len_i`, input, WIN_W: number of sample cycles in the window. Sampled only when `start_i` is accepted.
- `spike_i`, input, N_CLASSES: one spike flag per class, sampled each COUNT cycle.
- `count_o`, output, N_CLASSES*CNT_W: registered result. Lane k is `count_o[k*CNT_W +: CNT_W]`.
- `valid_o`, output, 1: high while `count_o` holds a completed window's result.
- `busy_o`, output, 1: high while in COUNT.
- `sat_o`, output, 1: high when any lane saturated in the reported window. Qualified by `valid_o`.

## Operation
- **FSM states:** IDLE, COUNT, DONE.
- **Reset values:**
  - State is IDLE.
  - All counters, `count_o`, `valid_o`, `busy_o` and `sat_o` are 0.
  - The window counter is 0.
- **Start acceptance (IDLE or DONE):** when `start_i`=1, the block:
  - clears the internal counters and the sticky saturation flag;
  - loads `remaining = window_len_i`;
  - clears `valid_o`;
  - enters COUNT.
- **Zero-length window:** if `window_len_i`=0, the block goes directly to DONE with all-zero counts. `valid_o` rises on the next cycle.
- **COUNT, every cycle:**
  - For each k with `spike_i[k]`=1, internal counter k increments by 1.
  - A counter at 2^CNT_W-1 holds its value and sets the sticky saturation flag.
  - `remaining` decrements by 1.
- **End of window (COUNT with `remaining`=1):** this is the last sample cycle.
  - Internal counter next-values, including this cycle's spikes, are written to `count_o`.
  - The saturation flag, including this cycle's saturation events, goes to `sat_o`.
  - `valid_o` is set to 1 and the state moves to DONE.
- **`start_i` during COUNT:** ignored. The window runs to completion.
- **DONE:** `count_o`, `sat_o` and `valid_o` hold indefinitely until a new start is accepted. `count_o` is not cleared on start; only `valid_o` drops.
- **Asynchronous reset mid-window:** returns to the reset values immediately. No partial result is reported.
- **Arithmetic:** unsigned only. The window counter is WIN_W bits wide, so the maximum window is 2^WIN_W-1 cycles.

## Timing
- **Start and sampling window:** with `start_i` accepted at edge T and L=`window_len_i`>0:
  - `busy_o`=1 for cycles T+1 through T+L.
  - `spike_i` is sampled on edges T+1 through T+L inclusive.
  - `valid_o`=1 and the new `count_o` become visible from cycle T+L+1.
- **Zero-length window:** `valid_o`=1 from cycle T+1, with `count_o` all zeros.
- **Back-to-back windows:** `start_i` asserted in the first DONE cycle is accepted. The minimum period is L+1 cycles.
- **Outputs:** all outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- **Shared package `snn_pkg`:**
  - `N_CLASSES` and `CNT_W` constants, shared with the max-spike stage so the lane widths agree.
  - The FSM state enum `cnt_state_t` (IDLE/COUNT/DONE).
- **Sub-module `sat_counter`:**
  - One instance per class; parameter CNT_W.
  - Inputs: `clr`, `inc`. Outputs: `q`, `q_next`, `sat_hit`.
  - Generated N_CLASSES times.
- **Top level:** FSM, window down-counter, output registers and the saturation OR-reduction.

## Test plan
- **Reset check:** assert `rst_ni`=0 asynchronously mid-cycle -> all outputs are 0 immediately. After release, IDLE with `valid_o`=0.
- **Basic window:** L=5, `spike_i[3]`=1 every cycle, `spike_i[7]`=1 on cycles 2 and 4 only -> at T+6, lane3=5, lane7=2, other lanes 0, `valid_o`=1, `sat_o`=0. `busy_o` is high exactly 5 cycles.
- **Saturation:** L=255 plus a second window, with lane 0 spiking every cycle of both -> lane0=255, `sat_o`=1. A following window of L=10 with no spikes reports lane0=0 and `sat_o`=0.
- **Ignored and back-to-back starts:**
  - `start_i` pulsed mid-COUNT -> no restart; the result appears at the original T+L+1.
  - `start_i` in the first DONE cycle -> `valid_o` drops next cycle and the new window runs.
- **Zero-length window:** `window_len_i`=0 with `spike_i`=all ones -> `valid_o`=1 at T+1 with all lanes 0.
- **Reset mid-COUNT:** reset at cycle T+3 of an L=10 window -> `valid_o` never rises for that window and all lanes read 0.

Source files
------------

// File: rtl/spike_counter_bank_pkg.sv
// rtl/spike_counter_bank_pkg.sv - shared class/lane sizing and counter FSM states
package snn_pkg;

  localparam int N_CLASSES = 10;
  localparam int CNT_W     = 8;
  localparam int WIN_W     = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } cnt_state_t;

endpackage

// File: rtl/spike_counter_bank_if.sv
// rtl/spike_counter_bank_if.sv - window control, spike input and result bundle
interface spike_counter_bank_if #(
  parameter int N_CLASSES = snn_pkg::N_CLASSES,
  parameter int CNT_W     = snn_pkg::CNT_W,
  parameter int WIN_W     = snn_pkg::WIN_W
);

  logic                       start_i;
  logic [WIN_W-1:0]           window_len_i;
  logic [N_CLASSES-1:0]       spike_i;
  logic [N_CLASSES*CNT_W-1:0] count_o;
  logic                       valid_o;
  logic                       busy_o;
  logic                       sat_o;

  modport master (
    output start_i, window_len_i, spike_i,
    input  count_o, valid_o, busy_o, sat_o
  );

  modport slave (
    input  start_i, window_len_i, spike_i,
    output count_o, valid_o, busy_o, sat_o
  );

endinterface

// File: rtl/spike_counter_bank_sat_counter.sv
// rtl/spike_counter_bank_sat_counter.sv - per-class saturating spike counter
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] q,
  output logic [CNT_W-1:0] q_next,
  output logic             sat_hit
);

  localparam logic [CNT_W-1:0] MAX_CNT = '1;

  logic [CNT_W-1:0] r_q;

  // sat_hit flags any increment that leaves the counter at full scale
  always_comb begin
    q_next  = r_q;
    sat_hit = 1'b0;
    if (clr) begin
      q_next = '0;
    end else if (inc) begin
      q_next  = (r_q == MAX_CNT) ? r_q : r_q + CNT_W'(1);
      sat_hit = (q_next == MAX_CNT);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_q <= '0;
    end else begin
      r_q <= q_next;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/spike_counter_bank.sv
// rtl/spike_counter_bank.sv - per-class spike counting over a programmable window
module spike_counter_bank #(
  parameter int N_CLASSES = snn_pkg::N_CLASSES,
  parameter int CNT_W     = snn_pkg::CNT_W,
  parameter int WIN_W     = snn_pkg::WIN_W
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  spike_counter_bank_if.slave  bus
);

  import snn_pkg::*;

  cnt_state_t                 r_state;
  cnt_state_t                 w_state_next;
  logic [WIN_W-1:0]           r_remaining;
  logic                       r_sat_sticky;
  logic [N_CLASSES*CNT_W-1:0] r_count;
  logic                       r_valid;
  logic                       r_busy;
  logic                       r_sat;

  logic                       w_counting;
  logic                       w_start_acc;
  logic                       w_zero_len;
  logic                       w_last;
  logic                       w_sat_any;
  logic [N_CLASSES-1:0]       w_sat_hit;
  logic [N_CLASSES*CNT_W-1:0] w_q_next;

  assign w_counting  = (r_state == COUNT);
  assign w_start_acc = bus.start_i && !w_counting;
  assign w_zero_len  = (bus.window_len_i == '0);
  assign w_last      = w_counting && (r_remaining == WIN_W'(1));
  assign w_sat_any   = |w_sat_hit;

  for (genvar k = 0; k < N_CLASSES; k++) begin : g_lane
    sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clr     (w_start_acc),
      .inc     (w_counting && bus.spike_i[k]),
      .q       (),
      .q_next  (w_q_next[k*CNT_W +: CNT_W]),
      .sat_hit (w_sat_hit[k])
    );
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE, DONE: if (bus.start_i) w_state_next = w_zero_len ? DONE : COUNT;
      COUNT:      if (w_last) w_state_next = DONE;
      default:    w_state_next = IDLE;
    endcase
  end

  // Results latch from q_next so the final sample cycle's spikes are included
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_remaining  <= '0;
      r_sat_sticky <= 1'b0;
      r_count      <= '0;
      r_valid      <= 1'b0;
      r_busy       <= 1'b0;
      r_sat        <= 1'b0;
    end else begin
      r_busy <= (w_state_next == COUNT);
      if (w_start_acc) begin
        r_remaining  <= bus.window_len_i;
        r_sat_sticky <= 1'b0;
        r_valid      <= w_zero_len;
        if (w_zero_len) begin
          r_count <= '0;
          r_sat   <= 1'b0;
        end
      end else if (w_counting) begin
        r_remaining  <= r_remaining - WIN_W'(1);
        r_sat_sticky <= r_sat_sticky | w_sat_any;
        if (w_last) begin
          r_count <= w_q_next;
          r_sat   <= r_sat_sticky | w_sat_any;
          r_valid <= 1'b1;
        end
      end
    end
  end

  assign bus.count_o = r_count;
  assign bus.valid_o = r_valid;
  assign bus.busy_o  = r_busy;
  assign bus.sat_o   = r_sat;

endmodule

// File: tb/tb_spike_counter_bank.sv
// tb/tb_spike_counter_bank.sv - randomized bench for spike_counter_bank against a spike-tally model
module tb_spike_counter_bank;

  localparam int NC    = 10;
  localparam int CW    = 8;
  localparam int WW    = 8;
  localparam int MAXC  = (1 << CW) - 1;

  logic clk;
  logic rst_n;

  int n_checks = 0;
  int n_fail   = 0;

  int unsigned raw_cnt [NC];
  int unsigned exp_lane[NC];
  bit          exp_sat;

  spike_counter_bank_if #(.N_CLASSES(NC), .CNT_W(CW), .WIN_W(WW)) bus ();

  spike_counter_bank #(.N_CLASSES(NC), .CNT_W(CW), .WIN_W(WW)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached (got timeout, wanted completion)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned lane(input int k);
    logic [CW-1:0] v;
    v = bus.count_o[k*CW +: CW];
    return int'(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_lanes(input string tag);
    for (int k = 0; k < NC; k++) check($sformatf("%s_lane%0d", tag, k), lane(k), exp_lane[k]);
  endtask

  function automatic logic [NC-1:0] pattern(input int mode, input int cyc);
    logic [NC-1:0] sp;
    sp = NC'($urandom);
    case (mode)
      1: begin
        sp = '0;
        sp[3] = 1'b1;
        sp[7] = (cyc == 2) || (cyc == 4);
      end
      2: sp[0] = 1'b1;
      3: sp = '0;
      default: ;
    endcase
    return sp;
  endfunction

  // Model: each class tallies its spikes, report is the tally clipped at full scale
  task automatic run_window(input string tag, input int len, input int mode, input bit mid_start);
    logic [NC-1:0] sp;
    int busy_cycles;
    for (int k = 0; k < NC; k++) raw_cnt[k] = 0;
    bus.start_i      = 1'b1;
    bus.window_len_i = WW'(len);
    bus.spike_i      = NC'($urandom);
    tick();
    bus.start_i = 1'b0;
    busy_cycles = 0;
    for (int i = 0; i < len; i++) begin
      if (bus.busy_o) busy_cycles++;
      if (i == 0) check({tag, "_valid_drop"}, bus.valid_o, 0);
      sp = pattern(mode, i + 1);
      bus.spike_i = sp;
      bus.start_i = mid_start && (i == len / 2);
      if (mid_start && i == len / 2) bus.window_len_i = WW'($urandom_range(1, 3));
      for (int k = 0; k < NC; k++) if (sp[k]) raw_cnt[k]++;
      tick();
      if (i < len - 1) begin
        n_checks++;
        if (bus.valid_o !== 1'b0) begin
          n_fail++;
          $display("FAIL %s_early_valid: got %0d expected 0 at cycle %0d", tag, bus.valid_o, i + 1);
        end
      end
    end
    bus.start_i = 1'b0;
    bus.spike_i = NC'($urandom);
    exp_sat = 1'b0;
    for (int k = 0; k < NC; k++) begin
      exp_lane[k] = (raw_cnt[k] > MAXC) ? MAXC : raw_cnt[k];
      if (raw_cnt[k] >= MAXC) exp_sat = 1'b1;
    end
    check({tag, "_busy_cycles"}, busy_cycles, len);
    check({tag, "_busy_after"}, bus.busy_o, 0);
    check({tag, "_valid"}, bus.valid_o, 1);
    check({tag, "_sat"}, bus.sat_o, exp_sat);
    check_lanes(tag);
  endtask

  task automatic hold_done(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      bus.spike_i = NC'($urandom);
      tick();
    end
    check({tag, "_hold_valid"}, bus.valid_o, 1);
    check({tag, "_hold_sat"}, bus.sat_o, exp_sat);
    check_lanes({tag, "_hold"});
  endtask

  initial begin
    rst_n            = 1'b0;
    bus.start_i      = 1'b0;
    bus.window_len_i = '0;
    bus.spike_i      = '0;
    #3;
    check("rst_valid", bus.valid_o, 0);
    check("rst_busy", bus.busy_o, 0);
    check("rst_sat", bus.sat_o, 0);
    check("rst_count", (bus.count_o == '0), 1);
    #10 rst_n = 1'b1;
    tick();
    check("idle_valid", bus.valid_o, 0);
    check("idle_busy", bus.busy_o, 0);

    run_window("basic", 5, 1, 1'b0);
    check("basic_lane3_abs", lane(3), 5);
    check("basic_lane7_abs", lane(7), 2);
    hold_done("basic", 4);

    for (int r = 0; r < 6; r++)
      run_window($sformatf("rand%0d", r), $urandom_range(1, 24), 0, 1'(r % 2));
    run_window("len1", 1, 0, 1'b1);
    hold_done("len1", 2);

    run_window("sat_a", 255, 2, 1'b0);
    check("sat_a_lane0_abs", lane(0), 255);
    run_window("sat_b", 255, 2, 1'b0);
    check("sat_b_flag_abs", bus.sat_o, 1);
    run_window("nosat", 10, 3, 1'b0);
    check("nosat_lane0_abs", lane(0), 0);
    check("nosat_flag_abs", bus.sat_o, 0);

    bus.start_i      = 1'b1;
    bus.window_len_i = '0;
    bus.spike_i      = '1;
    tick();
    bus.start_i = 1'b0;
    for (int k = 0; k < NC; k++) exp_lane[k] = 0;
    exp_sat = 1'b0;
    check("zero_valid", bus.valid_o, 1);
    check("zero_busy", bus.busy_o, 0);
    check("zero_sat", bus.sat_o, 0);
    check_lanes("zero");
    hold_done("zero", 3);

    run_window("prereset", 8, 2, 1'b0);
    bus.start_i      = 1'b1;
    bus.window_len_i = WW'(10);
    tick();
    bus.start_i = 1'b0;
    bus.spike_i = '1;
    tick();
    tick();
    #3 rst_n = 1'b0;
    #1;
    check("arst_valid", bus.valid_o, 0);
    check("arst_busy", bus.busy_o, 0);
    check("arst_sat", bus.sat_o, 0);
    for (int k = 0; k < NC; k++) exp_lane[k] = 0;
    check_lanes("arst");
    #10 rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      check("arst_no_valid", bus.valid_o, 0);
    end
    check_lanes("arst_after");

    run_window("post_reset", 7, 0, 1'b0);
    hold_done("post_reset", 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
